// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with optional skid entry (SKID=1) and
// bubble-zeroed control bundle. Optional perf counters under `PIPE_STAGE_PERF_EN`.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 143,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              R_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              xin;
    logic              xout;
    logic [CTRL_W-1:0] main_ctrl;

    assign xin      = in_valid & in_ready;
    assign xout     = out_valid & out_ready;
    // Control is gated so a bubble can never carry RegWrite/MemWrite downstream.
    assign out_ctrl = out_valid ? main_ctrl : '0;

    if (CNT_W < 1 || SKID < 0 || SKID > 1) begin : g_bad_param
        $error("pipe_stage_reg: CNT_W must be >= 1 and SKID must be 0 or 1");
    end

    if (SKID == 1) begin : g_skid
        typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

        state_t            state;
        logic              rdy_q;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        assign in_ready  = rdy_q;
        assign out_valid = (state != EMPTY);
        assign occ       = state;

        always_ff @(posedge clk or negedge R_n) begin
            if (!R_n) begin
                state     <= EMPTY;
                rdy_q     <= 1'b1;
                main_ctrl <= '0;
                out_data  <= '0;
                skid_ctrl <= '0;
                skid_data <= '0;
            end else if (flush) begin
                state     <= EMPTY;
                rdy_q     <= 1'b1;
                main_ctrl <= '0;
                out_data  <= '0;
                skid_ctrl <= '0;
                skid_data <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (xin) begin
                            state     <= ONE;
                            main_ctrl <= in_ctrl;
                            out_data  <= in_data;
                        end
                    end
                    ONE: begin
                        if (xin && !xout) begin
                            state     <= TWO;
                            rdy_q     <= 1'b0;
                            skid_ctrl <= in_ctrl;
                            skid_data <= in_data;
                        end else if (xin && xout) begin
                            main_ctrl <= in_ctrl;
                            out_data  <= in_data;
                        end else if (xout) begin
                            state     <= EMPTY;
                            main_ctrl <= '0;
                        end
                    end
                    TWO: begin
                        if (xout) begin
                            state     <= ONE;
                            rdy_q     <= 1'b1;
                            main_ctrl <= skid_ctrl;
                            out_data  <= skid_data;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        rdy_q <= 1'b1;
                    end
                endcase
            end
        end
    end else begin : g_single
        logic vld;

        assign in_ready  = !vld | out_ready;
        assign out_valid = vld;
        assign occ       = {1'b0, vld};

        always_ff @(posedge clk or negedge R_n) begin
            if (!R_n) begin
                vld       <= 1'b0;
                main_ctrl <= '0;
                out_data  <= '0;
            end else if (flush) begin
                vld       <= 1'b0;
                main_ctrl <= '0;
                out_data  <= '0;
            end else if (xin) begin
                vld       <= 1'b1;
                main_ctrl <= in_ctrl;
                out_data  <= in_data;
            end else if (xout) begin
                vld       <= 1'b0;
                main_ctrl <= '0;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (!out_valid && bubble_cnt != '1)             bubble_cnt <= bubble_cnt + 1'b1;
            if (flush && flush_cnt != '1)                   flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance (full widths) and a
// SKID=0 instance; perf counters checked when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         R_n;

    logic         flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   in_ctrl, out_ctrl;
    logic [142:0] in_data, out_data;
    logic [1:0]   occ;

    logic         flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0]   in_ctrl0, out_ctrl0;
    logic [15:0]  in_data0, out_data0;
    logic [1:0]   occ0;

`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]   stall_cnt, bubble_cnt, flush_cnt;
    logic [3:0]   stall_cnt0, bubble_cnt0, flush_cnt0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(143), .SKID(1), .CNT_W(4)) dut (
        .clk(clk), .R_n(R_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occ(occ)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .R_n(R_n), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occ(occ0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0), .flush_cnt(flush_cnt0)
`endif
    );

    // Advance one clock; inputs are changed by the caller 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        R_n = 1'b0;
        flush = 0; in_valid = 0; in_ctrl = 0; in_data = 0; out_ready = 0;
        flush0 = 0; in_valid0 = 0; in_ctrl0 = 0; in_data0 = 0; out_ready0 = 0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_ctrl !== 8'd0 || out_data !== 143'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b occ=%0d ctrl=%h data=%h, want 0/0/0/0", out_valid, occ, out_ctrl, out_data);
        end
        @(negedge clk); R_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: skid=%b single=%b, want 1/1", in_ready, in_ready0);
        end
        // fill to two entries then assert reset mid-cycle
        in_valid = 1; in_data = 143'h77; in_ctrl = 8'h77;
        step();
        in_data = 143'h78; in_ctrl = 8'h78;
        step();
        in_valid = 0;
        checks++;
        if (occ !== 2'd2) begin
            errors++;
            $display("FAIL reset_fill_occ: occ=%0d, want 2", occ);
        end
        #2 R_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_ctrl !== 8'd0 || out_data !== 143'd0) begin
            errors++;
            $display("FAIL reset_async: valid=%b occ=%0d ctrl=%h data=%h, want 0/0/0/0", out_valid, occ, out_ctrl, out_data);
        end
        @(negedge clk); R_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || occ !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b occ=%0d, want 1/0", in_ready, occ);
        end
    endtask

    task automatic test_stream();
        int nxt = 1, exp = 1, got = 0, first = -1;
        bit acc;
        out_ready = 1; in_valid = 1; in_data = 143'(nxt); in_ctrl = 8'(nxt);
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready: cycle %0d in_ready=%b, want 1", c, in_ready);
                end
            end
            checks++;
            if (out_valid) begin
                if (first < 0) first = c;
                if (out_data !== 143'(exp) || out_ctrl !== 8'(exp)) begin
                    errors++;
                    $display("FAIL stream_data: got data=%0d ctrl=%0d, want %0d", out_data, out_ctrl, exp);
                end
                exp++; got++;
            end else if (out_ctrl !== 8'd0) begin
                errors++;
                $display("FAIL stream_bubble_ctrl: ctrl=%h, want 0", out_ctrl);
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                if (nxt == 100) in_valid = 0;
                else begin nxt++; in_data = 143'(nxt); in_ctrl = 8'(nxt); end
            end
        end
        checks++;
        if (got !== 100 || first !== 1) begin
            errors++;
            $display("FAIL stream_count: got %0d items first at cycle %0d, want 100 at cycle 1", got, first);
        end
    endtask

    task automatic test_stall_fill();
        logic [142:0] expq [3];
        int got = 0;
        bit acc, pop;
        expq[0] = 143'hA; expq[1] = 143'hB; expq[2] = 143'hC;
        out_ready = 0; in_valid = 1; in_data = 143'hA; in_ctrl = 8'hA;
        step();
        checks++;
        if (occ !== 2'd1 || in_ready !== 1'b1 || out_data !== 143'hA) begin
            errors++;
            $display("FAIL fill_one: occ=%0d in_ready=%b data=%h, want 1/1/a", occ, in_ready, out_data);
        end
        in_data = 143'hB; in_ctrl = 8'hB;
        step();
        checks++;
        if (occ !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_two: occ=%0d in_ready=%b, want 2/0", occ, in_ready);
        end
        in_data = 143'hC; in_ctrl = 8'hC;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== 143'hA || out_ctrl !== 8'hA || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: occ=%0d in_ready=%b data=%h ctrl=%h, want 2/0/a/a", occ, in_ready, out_data, out_ctrl);
            end
        end
        out_ready = 1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                checks++;
                if (out_data !== expq[got]) begin
                    errors++;
                    $display("FAIL drain_order: item %0d data=%h, want %h", got, out_data, expq[got]);
                end
                got++;
            end
            step();
            if (acc) in_valid = 0;
        end
        checks++;
        if (got !== 3 || occ !== 2'd0) begin
            errors++;
            $display("FAIL drain_count: got %0d occ=%0d, want 3/0", got, occ);
        end
    endtask

    task automatic test_flush();
        bit seen = 0;
        out_ready = 0; in_valid = 1; in_data = 143'h11; in_ctrl = 8'h11;
        step();
        in_data = 143'h22; in_ctrl = 8'h22;
        step();
        checks++;
        if (occ !== 2'd2) begin
            errors++;
            $display("FAIL flush_setup: occ=%0d, want 2", occ);
        end
        flush = 1; in_data = 143'h55; in_ctrl = 8'h55;
        step();
        flush = 0; in_valid = 0;
        checks++;
        if (occ !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 8'd0 || out_data !== 143'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two: occ=%0d valid=%b ctrl=%h data=%h in_ready=%b, want 0/0/0/0/1",
                     occ, out_valid, out_ctrl, out_data, in_ready);
        end
        // flush from one entry while the incoming entry is accepted
        in_valid = 1; in_data = 143'h33; in_ctrl = 8'h33;
        step();
        flush = 1; in_data = 143'h66; in_ctrl = 8'h66;
        step();
        flush = 0; in_valid = 0; out_ready = 1;
        checks++;
        if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== 143'd0) begin
            errors++;
            $display("FAIL flush_one: occ=%0d valid=%b data=%h, want 0/0/0", occ, out_valid, out_data);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: flushed entry reached output (valid seen=%b), want 0", seen);
        end
    endtask

    task automatic test_skid0();
        int nxt = 1, exp = 1, got = 0;
        bit acc;
        in_valid0 = 1; in_data0 = 16'(nxt); in_ctrl0 = 8'(nxt);
        for (int c = 0; c < 60; c++) begin
            out_ready0 = (c % 3 != 1);
            @(negedge clk);
            checks++;
            if (in_ready0 !== (!out_valid0 | out_ready0)) begin
                errors++;
                $display("FAIL single_in_ready: cycle %0d in_ready=%b valid=%b out_ready=%b", c, in_ready0, out_valid0, out_ready0);
            end
            if (out_valid0 && out_ready0) begin
                checks++;
                if (out_data0 !== 16'(exp) || out_ctrl0 !== 8'(exp)) begin
                    errors++;
                    $display("FAIL single_data: got %0d, want %0d", out_data0, exp);
                end
                exp++; got++;
            end
            if (!out_valid0 && out_ctrl0 !== 8'd0) begin
                checks++; errors++;
                $display("FAIL single_bubble_ctrl: ctrl=%h, want 0", out_ctrl0);
            end
            acc = in_valid0 && in_ready0;
            step();
            if (acc) begin
                if (nxt == 10) in_valid0 = 0;
                else begin nxt++; in_data0 = 16'(nxt); in_ctrl0 = 8'(nxt); end
            end
        end
        checks++;
        if (got !== 10 || occ0 !== 2'd0) begin
            errors++;
            $display("FAIL single_count: got %0d occ=%0d, want 10/0", got, occ0);
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        R_n = 0; in_valid = 0; flush = 0; out_ready = 1;
        #1;
        checks++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL perf_reset: stall=%0d bubble=%0d flush=%0d, want 0", stall_cnt, bubble_cnt, flush_cnt);
        end
        @(negedge clk); R_n = 1;
        step();
        flush = 1;
        for (int k = 0; k < 3; k++) step();
        flush = 0;
        checks++;
        if (flush_cnt !== 4'd3) begin
            errors++;
            $display("FAIL perf_flush: flush_cnt=%0d, want 3", flush_cnt);
        end
        out_ready = 0; in_valid = 1; in_data = 143'h9; in_ctrl = 8'h9;
        step();
        in_valid = 0;
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (stall_cnt !== 4'd15 || out_data !== 143'h9 || flush_cnt !== 4'd3) begin
            errors++;
            $display("FAIL perf_stall: stall_cnt=%0d data=%h flush_cnt=%0d, want 15/9/3", stall_cnt, out_data, flush_cnt);
        end
        out_ready = 1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_skid0();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register; generic successor to the fixed-field inter-stage latches between ID/EX/MEM/WB of the 5-stage RV32I core.
- Carries a control bundle (zeroed on bubble/flush) and a data bundle (PC, immediates, operands, register addresses) with valid/ready flow control, stall back-pressure, synchronous flush and an optional skid entry for full throughput under registered ready.

Parameters:
- CTRL_W, 8, width of the control bundle (MemtoReg, RegWrite, MemWrite, MemRead, ALUSrc, ALUCode ...); forced to 0 whenever the stage holds no valid entry.
- DATA_W, 143, width of the data bundle (PC, Imm, rs1Data, rs2Data, rd/rs1/rs2 addresses).
- SKID, 1, 1 adds a 2nd entry (skid) and registers in_ready; 0 gives a single entry with combinational in_ready.
- CNT_W, 16, perf counter width (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- R_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held and incoming entries (branch taken / load-use bubble).
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts (deassert = stall).
- out_ctrl  output  CTRL_W  control bundle; 0 when out_valid=0.
- out_data  output  DATA_W  data bundle; 0 after reset/flush until the next load.
- occ  output  2  entries held (0..1 when SKID=0, 0..2 when SKID=1).

Behaviour:
- Reset (R_n=0, async): out_valid=0, out_ctrl=0, out_data=0, skid cleared, occ=0; in_ready=1 once R_n releases (SKID=1: in_ready register resets to 1).
- Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
- Latency: 1 cycle in->out when empty; no combinational path from in_* to out_*.
- SKID=0: in_ready = !out_valid | out_ready. Load main register on transfer in; else clear out_valid on transfer out.
- SKID=1, states EMPTY(occ=0), ONE(occ=1), TWO(occ=2):
  - EMPTY: transfer in -> ONE.
  - ONE: in only -> TWO (incoming to skid); out only -> EMPTY; in & out -> ONE (main reloaded from input).
  - TWO: in_ready=0; out -> ONE, skid moves to main the same edge.
  - in_ready = (state != TWO), registered.
- Ordering strictly FIFO; no entry dropped or duplicated except on flush.
- Stall: out_ready=0 holds out_* bit-stable for any number of cycles.
- Flush (priority over every transfer): next edge -> EMPTY, out_valid=0, out_ctrl=0, out_data=0; an entry accepted on the flush cycle is discarded; in_ready=1 the following cycle.
- Bubble: any cycle out_valid=0 presents out_ctrl=0 (RegWrite/MemWrite inactive downstream).
- Reset mid-transfer: async clear wins; held entries lost.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[CNT_W] (+1 each cycle out_valid & !out_ready), bubble_cnt[CNT_W] (+1 each cycle out_valid=0 outside reset) and flush_cnt[CNT_W] (+1 per cycle flush=1). All saturate at all-ones, reset to 0 by R_n; flush does not clear them.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset: R_n=0 asserted mid-cycle with occ=2 -> immediately out_valid=0, out_ctrl=0, out_data=0, occ=0; after release in_ready=1.
- Streaming, SKID=1, out_ready=1, in_valid=1 with data 1,2,3...,100 -> out_data 1..100 in order, one per cycle after 1-cycle latency, in_ready stays 1.
- Stall fill: out_ready=0 while feeding 0xA, 0xB, 0xC -> occ goes 1,2; in_ready=0 at occ=2; 0xC held upstream; release -> outputs 0xA, 0xB, 0xC in order with no loss.
- Flush priority: occ=2, flush=1 with in_valid=1, in_data=0x55 -> next cycle occ=0, out_valid=0, out_ctrl=0; 0x55 never appears at the output.
- SKID=0 build: out_ready toggled 1,0,1 with in_valid=1 -> in_ready follows !out_valid|out_ready combinationally; output sequence identical to SKID=1 aside from throughput.
- PIPE_STAGE_PERF_EN with CNT_W=4: hold stall 20 cycles -> stall_cnt saturates at 15; flush pulsed 3 cycles -> flush_cnt=3.
